// File: rtl/sap1_controlador_sequenciador_if.sv
// ----------------------------------------------------------------------------
// sap1_controlador_sequenciador_if
//   Bundle between the SAP-1 controller-sequencer and the datapath it steers.
//   opcode   : IR[7:4] presented to the controller
//   ctrl     : 12-bit control word {Cp,Ep,n_Lm,n_CE,n_Li,n_Ei,n_La,Ea,Su,Eu,n_Lb,n_Lo}
//   t_state  : one-hot ring state (bit0=T1 .. bit5=T6), all zero when idle
//   halted   : set once HLT has been decoded
//   master   : the controller side (drives ctrl/t_state/halted)
//   slave    : the datapath side (drives opcode)
// ----------------------------------------------------------------------------
interface sap1_controlador_sequenciador_if;
    logic [3:0]  opcode;
    logic [11:0] ctrl;
    logic [5:0]  t_state;
    logic        halted;

    modport master (
        input  opcode,
        output ctrl,
        output t_state,
        output halted
    );

    modport slave (
        output opcode,
        input  ctrl,
        input  t_state,
        input  halted
    );
endinterface

// File: rtl/sap1_controlador_sequenciador.sv
// ----------------------------------------------------------------------------
// sap1_controlador_sequenciador
//   Controller-sequencer for the SAP-1 datapath. A six-state ring counter
//   (T1..T6) walks the fetch cycle (T1..T3) and the execute cycle (T4..T6),
//   decoding the IR opcode into the 12-bit control word.
//   The ring advances on the falling clock edge so each control line has half
//   a clock to settle before the rising-edge datapath registers consume it.
// Ports
//   clk    : system clock (state updates on negedge)
//   n_rst  : asynchronous reset, active-low
//   bus    : master modport -> opcode in, ctrl/t_state/halted out
// ----------------------------------------------------------------------------
module sap1_controlador_sequenciador (
    input  logic                                   clk,
    input  logic                                   n_rst,
    sap1_controlador_sequenciador_if.master        bus
);

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control-word bit positions.
    localparam int B_CP   = 11;
    localparam int B_EP   = 10;
    localparam int B_NLM  = 9;
    localparam int B_NCE  = 8;
    localparam int B_NLI  = 7;
    localparam int B_NEI  = 6;
    localparam int B_NLA  = 5;
    localparam int B_EA   = 4;
    localparam int B_SU   = 3;
    localparam int B_EU   = 2;
    localparam int B_NLB  = 1;
    localparam int B_NLO  = 0;

    // All enables inactive: active-high lines low, active-low lines high.
    localparam logic [11:0] CTRL_NOP = 12'b0011_1110_0011;

    // State encoding is the one-hot t_state value itself, so the output is
    // the state register with no decode.
    typedef enum logic [5:0] {
        S_IDLE = 6'b000000,
        S_T1   = 6'b000001,
        S_T2   = 6'b000010,
        S_T3   = 6'b000100,
        S_T4   = 6'b001000,
        S_T5   = 6'b010000,
        S_T6   = 6'b100000
    } state_t;

    state_t      state_q;
    logic        halted_q;
    logic [11:0] ctrl_comb;

    always_ff @(negedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            case (state_q)
                S_IDLE: state_q <= S_T1;
                S_T1:   state_q <= S_T2;
                S_T2:   state_q <= S_T3;
                S_T3:   state_q <= S_T4;
                S_T4: begin
                    // HLT freezes the ring at T4; only reset releases it.
                    if (bus.opcode == OP_HLT) begin
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_T5;
                    end
                end
                S_T5:   state_q <= S_T6;
                S_T6:   state_q <= S_T1;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Control word is combinational on (state, opcode, halted) so it is valid
    // in the same half-cycle the state changes.
    always_comb begin
        ctrl_comb = CTRL_NOP;
        if (!halted_q) begin
            case (state_q)
                S_T1: begin
                    ctrl_comb[B_EP]  = 1'b1;
                    ctrl_comb[B_NLM] = 1'b0;
                end
                S_T2: begin
                    ctrl_comb[B_CP]  = 1'b1;
                end
                S_T3: begin
                    ctrl_comb[B_NCE] = 1'b0;
                    ctrl_comb[B_NLI] = 1'b0;
                end
                S_T4: begin
                    if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        ctrl_comb[B_NLM] = 1'b0;
                        ctrl_comb[B_NEI] = 1'b0;
                    end else if (bus.opcode == OP_OUT) begin
                        ctrl_comb[B_EA]  = 1'b1;
                        ctrl_comb[B_NLO] = 1'b0;
                    end
                end
                S_T5: begin
                    if (bus.opcode == OP_LDA) begin
                        ctrl_comb[B_NCE] = 1'b0;
                        ctrl_comb[B_NLA] = 1'b0;
                    end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        ctrl_comb[B_NCE] = 1'b0;
                        ctrl_comb[B_NLB] = 1'b0;
                        // Su is raised early so the ALU output settles before T6.
                        ctrl_comb[B_SU]  = (bus.opcode == OP_SUB);
                    end
                end
                S_T6: begin
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        ctrl_comb[B_EU]  = 1'b1;
                        ctrl_comb[B_NLA] = 1'b0;
                        ctrl_comb[B_SU]  = (bus.opcode == OP_SUB);
                    end
                end
                default: ctrl_comb = CTRL_NOP;
            endcase
        end
    end

    assign bus.ctrl    = ctrl_comb;
    assign bus.t_state = state_q;
    assign bus.halted  = halted_q;

endmodule
